// File: rtl/siteswap_player.sv
// Beat-driven siteswap player: latches a validated pattern, then emits one throw per beat
// while tracking in-flight balls in a shifting landing schedule.
module siteswap_player #(
   parameter int MAX_LEN = 7,
   parameter int SLOTS   = 8,
   parameter int BALL_W  = 3
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        new_beat,
   input  logic [MAX_LEN-1:0][2:0]     pattern_in,
   input  logic [2:0]                  pattern_length,
   input  logic [2:0]                  num_balls_in,
   input  logic                        pattern_valid_in,
   output logic                        playing_out,
   output logic                        throw_valid_out,
   output logic [2:0]                  throw_height_out,
   output logic [BALL_W-1:0]           throw_ball_out,
   output logic                        throw_ball_valid_out,
   output logic                        throw_hand_out,
   output logic [2:0]                  beat_pos_out,
   output logic                        error_out
);

   localparam int SLOT_W = $clog2(SLOTS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic load_en, beat_en, abort_en, playing;

   logic [2:0]        shadow_q [MAX_LEN];
   logic [2:0]        len_q;
   logic [2:0]        pos_q;
   logic              hand_q;
   logic              error_q;

   logic              occ_q [SLOTS];
   logic [BALL_W-1:0] id_q  [SLOTS];
   logic              occ_d [SLOTS];
   logic [BALL_W-1:0] id_d  [SLOTS];

   logic              tvalid_q;
   logic [2:0]        theight_q;
   logic [BALL_W-1:0] tball_q;
   logic              tball_valid_q;
   logic              thand_q;
   logic [2:0]        tpos_q;

   logic [2:0]        cur_h;
   logic [SLOT_W-1:0] land_idx;
   logic              collide;
   logic              drop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (pattern_valid_in && (pattern_length != 3'd0)) state_d = S_LOAD;
         S_LOAD: state_d = S_PLAY;
         S_PLAY: if (!pattern_valid_in) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Losing the pattern outranks a same-cycle beat, so beat_en requires valid.
   always_comb begin
      load_en  = 1'b0;
      beat_en  = 1'b0;
      abort_en = 1'b0;
      playing  = 1'b0;
      case (state_q)
         S_LOAD: load_en = 1'b1;
         S_PLAY: begin
            playing  = 1'b1;
            abort_en = !pattern_valid_in;
            beat_en  = pattern_valid_in && new_beat;
         end
         default: ;
      endcase
   end

   assign cur_h    = shadow_q[pos_q];
   assign land_idx = SLOT_W'(cur_h) - SLOT_W'(1);
   assign drop     = beat_en && (cur_h == 3'd0) && occ_q[0];

   // ---------------- landing schedule next state ----------------
   always_comb begin
      collide = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         occ_d[i] = occ_q[i];
         id_d[i]  = id_q[i];
      end
      if (load_en) begin
         for (int i = 0; i < SLOTS; i++) begin
            occ_d[i] = (i < int'(num_balls_in));
            id_d[i]  = (i < int'(num_balls_in)) ? BALL_W'(i) : '0;
         end
      end else if (abort_en) begin
         for (int i = 0; i < SLOTS; i++) begin
            occ_d[i] = 1'b0;
            id_d[i]  = '0;
         end
      end else if (beat_en) begin
         for (int i = 0; i < SLOTS - 1; i++) begin
            occ_d[i] = occ_q[i+1];
            id_d[i]  = id_q[i+1];
         end
         occ_d[SLOTS-1] = 1'b0;
         id_d[SLOTS-1]  = '0;
         // The ball in hand lands h-1 beats after the shift; a resident ball is overwritten.
         if ((cur_h != 3'd0) && occ_q[0]) begin
            for (int i = 0; i < SLOTS; i++) begin
               if (SLOT_W'(i) == land_idx) begin
                  collide  = occ_d[i];
                  occ_d[i] = 1'b1;
                  id_d[i]  = id_q[0];
               end
            end
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < SLOTS; i++) begin
            occ_q[i] <= 1'b0;
            id_q[i]  <= '0;
         end
         for (int i = 0; i < MAX_LEN; i++) begin
            shadow_q[i] <= 3'd0;
         end
         len_q         <= 3'd0;
         pos_q         <= 3'd0;
         hand_q        <= 1'b0;
         error_q       <= 1'b0;
         tvalid_q      <= 1'b0;
         theight_q     <= 3'd0;
         tball_q       <= '0;
         tball_valid_q <= 1'b0;
         thand_q       <= 1'b0;
         tpos_q        <= 3'd0;
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            occ_q[i] <= occ_d[i];
            id_q[i]  <= id_d[i];
         end
         tvalid_q <= beat_en;
         if (load_en) begin
            for (int i = 0; i < MAX_LEN; i++) begin
               shadow_q[i] <= pattern_in[i];
            end
            len_q   <= pattern_length;
            pos_q   <= 3'd0;
            hand_q  <= 1'b0;
            error_q <= 1'b0;
         end
         if (beat_en) begin
            theight_q     <= cur_h;
            tpos_q        <= pos_q;
            thand_q       <= hand_q;
            tball_valid_q <= occ_q[0];
            tball_q       <= occ_q[0] ? id_q[0] : '0;
            pos_q         <= (pos_q == len_q - 3'd1) ? 3'd0 : pos_q + 3'd1;
            hand_q        <= ~hand_q;
            if (collide || drop) begin
               error_q <= 1'b1;
            end
         end
      end
   end

   assign playing_out          = playing;
   assign throw_valid_out      = tvalid_q;
   assign throw_height_out     = theight_q;
   assign throw_ball_out       = tball_q;
   assign throw_ball_valid_out = tball_valid_q;
   assign throw_hand_out       = thand_q;
   assign beat_pos_out         = tpos_q;
   assign error_out            = error_q;

endmodule
